// File: rtl/sync_fifo_prog_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
package fifo_pkg;

  localparam int unsigned MIN_DEPTH = 4;

  // Bit positions inside the registered status vector
  localparam int unsigned FLAG_EMPTY      = 0;
  localparam int unsigned FLAG_FULL       = 1;
  localparam int unsigned FLAG_PROG_EMPTY = 2;
  localparam int unsigned FLAG_PROG_FULL  = 3;
  localparam int unsigned NUM_FLAGS       = 4;

  // Modular pointer difference; callers truncate to their AW+1 pointer width
  function automatic logic [31:0] ptr_cnt(input logic [31:0] wptr,
                                          input logic [31:0] rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_ramdp.sv
// Simple dual-port RAM, one write port and one registered read port on clk.
module ramdp #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive rst
  always_ff @(posedge clk) begin
    if (rst)     r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, fill count and optional
// sticky overflow/underflow flags (enabled by defining SYNC_FIFO_ERR_EN).
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wren,
  input  logic [DW-1:0]              wdata,
  output logic                       wfull,
  input  logic [$clog2(DEPTH):0]     prog_full_thr,
  output logic                       prog_full,
  input  logic                       rden,
  output logic [DW-1:0]              rdata,
  output logic                       rempty,
  input  logic [$clog2(DEPTH):0]     prog_empty_thr,
  output logic                       prog_empty,
  output logic [$clog2(DEPTH):0]     data_cnt,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of two >= MIN_DEPTH");
  end

  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic [AW:0]            r_cnt;
  logic [NUM_FLAGS-1:0]   r_flags;

  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic [AW:0]            w_wptr_nxt;
  logic [AW:0]            w_rptr_nxt;
  logic [AW:0]            w_cnt_nxt;

  // Registered flags gate acceptance, so full refuses a write even with a
  // concurrent read, and empty refuses a read even with a concurrent write.
  assign w_wr_acc   = wren & ~r_flags[FLAG_FULL];
  assign w_rd_acc   = rden & ~r_flags[FLAG_EMPTY];
  assign w_wptr_nxt = r_wptr + (AW+1)'(w_wr_acc);
  assign w_rptr_nxt = r_rptr + (AW+1)'(w_rd_acc);
  assign w_cnt_nxt  = (AW+1)'(ptr_cnt(32'(w_wptr_nxt), 32'(w_rptr_nxt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr                   <= '0;
      r_rptr                   <= '0;
      r_cnt                    <= '0;
      r_flags                  <= '0;
      r_flags[FLAG_EMPTY]      <= 1'b1;
      r_flags[FLAG_PROG_EMPTY] <= 1'b1;
    end else begin
      r_wptr                   <= w_wptr_nxt;
      r_rptr                   <= w_rptr_nxt;
      r_cnt                    <= w_cnt_nxt;
      r_flags[FLAG_EMPTY]      <= (w_cnt_nxt == '0);
      r_flags[FLAG_FULL]       <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_flags[FLAG_PROG_EMPTY] <= (w_cnt_nxt <= prog_empty_thr);
      r_flags[FLAG_PROG_FULL]  <= (w_cnt_nxt >= prog_full_thr);
    end
  end

  assign data_cnt   = r_cnt;
  assign rempty     = r_flags[FLAG_EMPTY];
  assign wfull      = r_flags[FLAG_FULL];
  assign prog_empty = r_flags[FLAG_PROG_EMPTY];
  assign prog_full  = r_flags[FLAG_PROG_FULL];

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf;
  logic r_unf;

  // A new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (wren & r_flags[FLAG_FULL])  | (r_ovf & ~err_clr);
      r_unf <= (rden & r_flags[FLAG_EMPTY]) | (r_unf & ~err_clr);
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

  ramdp #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_acc),
    .waddr (r_wptr[AW-1:0]),
    .wdata (wdata),
    .re    (w_rd_acc),
    .raddr (r_rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_sync_fifo_prog;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = $clog2(DEPTH);

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wren = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wfull;
  logic [AW:0]   prog_full_thr = (AW+1)'(24);
  logic          prog_full;
  logic          rden = 1'b0;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [AW:0]   prog_empty_thr = (AW+1)'(4);
  logic          prog_empty;
  logic [AW:0]   data_cnt;
  logic          err_clr = 1'b0;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wren           (wren),
    .wdata          (wdata),
    .wfull          (wfull),
    .prog_full_thr  (prog_full_thr),
    .prog_full      (prog_full),
    .rden           (rden),
    .rdata          (rdata),
    .rempty         (rempty),
    .prog_empty_thr (prog_empty_thr),
    .prog_empty     (prog_empty),
    .data_cnt       (data_cnt),
    .err_clr        (err_clr),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags derived from its size
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  bit            m_pf, m_pe, m_ovf, m_unf;
  bit            m_wa, m_ra, m_full, m_empty;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdata = '0;
      m_pf = 1'b0; m_pe = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      m_wa = wren && !m_full;
      m_ra = rden && !m_empty;
      if (ERR_EN) begin
        m_ovf = (wren && m_full)  ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_unf = (rden && m_empty) ? 1'b1 : (err_clr ? 1'b0 : m_unf);
      end
      if (m_ra) m_rdata = q.pop_front();
      if (m_wa) q.push_back(wdata);
      m_pf = (q.size() >= int'(prog_full_thr));
      m_pe = (q.size() <= int'(prog_empty_thr));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_cnt",       32'(data_cnt),   32'(q.size()));
      check("m_rempty",    32'(rempty),     32'(q.size() == 0));
      check("m_wfull",     32'(wfull),      32'(q.size() == DEPTH));
      check("m_rdata",     32'(rdata),      32'(m_rdata));
      check("m_prog_full", 32'(prog_full),  32'(m_pf));
      check("m_prog_empty",32'(prog_empty), 32'(m_pe));
      check("m_overflow",  32'(overflow),   32'(m_ovf));
      check("m_underflow", 32'(underflow),  32'(m_unf));
    end
  end

  // Apply inputs, clock once, then settle 2 time units past the edge
  task automatic tick(input bit w, input logic [DW-1:0] d, input bit r);
    wren = w; wdata = d; rden = r;
    @(posedge clk);
    #2;
    wren = 1'b0; rden = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1 Reset
    rst = 1'b1;
    tick(0, '0, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_rempty", 32'(rempty), 1);
    check("rst_wfull",  32'(wfull), 0);
    check("rst_cnt",    32'(data_cnt), 0);
    check("rst_rdata",  32'(rdata), 0);
    check("rst_pempty", 32'(prog_empty), 1);

    // 2 Fill; prog_empty falls at 5, prog_full rises at 24
    for (int i = 0; i < 32; i++) begin
      tick(1, DW'(i), 0);
      check("fill_cnt",   32'(data_cnt), 32'(i + 1));
      check("fill_pfull", 32'(prog_full), 32'(i + 1 >= 24));
      check("fill_pempty",32'(prog_empty), 32'(i + 1 <= 4));
    end
    check("fill_wfull", 32'(wfull), 1);
    tick(1, 16'hBEEF, 0);
    check("ovf_cnt",  32'(data_cnt), 32);
    check("ovf_flag", 32'(overflow), 32'(ERR_EN));
    err_clr = 1'b1;
    tick(0, '0, 0);
    check("ovf_clr", 32'(overflow), 0);

    // 3 Drain
    for (int i = 0; i < 32; i++) begin
      tick(0, '0, 1);
      check("drain_rdata", 32'(rdata), 32'(i));
    end
    check("drain_rempty", 32'(rempty), 1);
    tick(0, '0, 1);
    check("unf_flag",  32'(underflow), 32'(ERR_EN));
    check("unf_rdata", 32'(rdata), 32'h1F);
    err_clr = 1'b1;
    tick(0, '0, 1);
    check("unf_clr_wins", 32'(underflow), 32'(ERR_EN));
    err_clr = 1'b1;
    tick(0, '0, 0);
    check("unf_clr", 32'(underflow), 0);

    // 4 Simultaneous read/write at count 10
    for (int i = 0; i < 10; i++) tick(1, DW'(16'h100 + i), 0);
    for (int k = 0; k < 100; k++) begin
      tick(1, DW'(16'h200 + k), 1);
      check("sim_cnt", 32'(data_cnt), 10);
      check("sim_rdata", 32'(rdata), (k < 10) ? 32'(16'h100 + k) : 32'(16'h200 + k - 10));
    end
    for (int i = 0; i < 10; i++) tick(0, '0, 1);
    check("sim_last", 32'(rdata), 32'(16'h200 + 99));
    check("sim_empty", 32'(rempty), 1);

    // 5 Threshold change takes effect one edge later
    for (int i = 0; i < 6; i++) tick(1, DW'(16'h300 + i), 0);
    check("thr_pe_before", 32'(prog_empty), 0);
    prog_empty_thr = (AW+1)'(8);
    #1;
    check("thr_pe_hold", 32'(prog_empty), 0);
    tick(0, '0, 0);
    check("thr_pe_after", 32'(prog_empty), 1);

    // 6 Edge cases: read+write at full, then at empty
    for (int i = 0; i < 26; i++) tick(1, DW'(16'h400 + i), 0);
    check("edge_full", 32'(wfull), 1);
    tick(1, 16'hDEAD, 1);
    check("edge_full_cnt", 32'(data_cnt), 31);
    check("edge_full_rd",  32'(rdata), 32'h300);
    for (int i = 0; i < 31; i++) tick(0, '0, 1);
    check("edge_drained", 32'(rempty), 1);
    tick(1, 16'h5A5A, 1);
    check("edge_empty_cnt",   32'(data_cnt), 1);
    check("edge_empty_flag",  32'(rempty), 0);
    check("edge_empty_rdata", 32'(rdata), 32'h419);
    tick(0, '0, 1);
    check("edge_wr_then_rd", 32'(rdata), 32'h5A5A);

    // Reset in the middle of a burst at count 17
    for (int i = 0; i < 17; i++) tick(1, DW'(16'h600 + i), 0);
    check("rst17_cnt", 32'(data_cnt), 17);
    rst = 1'b1;
    tick(1, 16'h7777, 1);
    rst = 1'b0;
    check("rst17_cnt0",  32'(data_cnt), 0);
    check("rst17_empty", 32'(rempty), 1);
    check("rst17_rdata", 32'(rdata), 0);
    check("rst17_pf",    32'(prog_full), 0);
    check("rst17_pe",    32'(prog_empty), 1);

    // prog_full_thr = 0 forces prog_full on the first cycle after reset
    prog_full_thr = '0;
    rst = 1'b1;
    tick(0, '0, 0);
    rst = 1'b0;
    check("pf0_reset", 32'(prog_full), 0);
    tick(0, '0, 0);
    check("pf0_set", 32'(prog_full), 1);
    tick(0, '0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
